if_fetch_stage: RTL and testbench

- Instruction-fetch stage control and IF/ID pipeline register. Sits directly downstream of the IF PC register.
- Issues an instruction-memory request for the current PC_IF and holds the PC register through pc_stall until the request is granted.
- Buffers one returned instruction and presents it to decode as Instr_ID, PC_ID and PC_Plus4_ID with a valid flag.
- Supports a decode stall and a branch/jump flush.

---
 rtl/if_fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch control FSM (REQ/WAIT/FULL) and IF/ID pipeline register.
// Define IF_MISALIGN_CHK_EN to add the PC alignment check and the Misalign_ID output.
module if_fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC_IF,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              if_flush,
  output logic [DATA_W-1:0] Instr_ID,
  output logic [ADDR_W-1:0] PC_ID,
  output logic [ADDR_W-1:0] PC_Plus4_ID,
`ifdef IF_MISALIGN_CHK_EN
  output logic              Misalign_ID,
`endif
  output logic              Valid_ID
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;

  logic              can_load, misalign, gnt_acc, mis_load, load_en;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] load_pc;

  assign can_load = !valid_q || !id_stall;

`ifdef IF_MISALIGN_CHK_EN
  assign misalign    = (PC_IF[1:0] != 2'b00);
  assign Misalign_ID = mis_q;
`else
  assign misalign = 1'b0;
`endif

  // State register and fetch bookkeeping
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_REQ;
      drop_q      <= 1'b0;
      req_pc_q    <= '0;
      hold_pc_q   <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_pc_q    <= req_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Next-state logic; also selects what (if anything) loads the ID register
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    req_pc_d    = req_pc_q;
    hold_pc_d   = hold_pc_q;
    hold_data_d = hold_data_q;
    load_en     = 1'b0;
    load_data   = hold_data_q;
    load_pc     = hold_pc_q;
    case (state_q)
      S_REQ: begin
        if (gnt_acc) begin
          state_d  = S_WAIT;
          req_pc_d = PC_IF;
          drop_d   = if_flush;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || if_flush) begin
            state_d = S_REQ;
          end else if (can_load) begin
            state_d   = S_REQ;
            load_en   = 1'b1;
            load_data = imem_rdata;
            load_pc   = req_pc_q;
          end else begin
            state_d     = S_FULL;
            hold_data_d = imem_rdata;
            hold_pc_d   = req_pc_q;
          end
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end
      S_FULL: begin
        if (if_flush) begin
          state_d = S_REQ;
        end else if (can_load) begin
          state_d = S_REQ;
          load_en = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req  = (state_q == S_REQ) && !misalign && !Reset;
    imem_addr = PC_IF;
    gnt_acc   = (state_q == S_REQ) && !misalign && imem_gnt;
    mis_load  = (state_q == S_REQ) && misalign && can_load && !if_flush;
    pc_stall  = !(gnt_acc || if_flush || mis_load);
  end

  // ID register: flush beats load, load beats consume, stall holds everything
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (if_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      mis_d   = 1'b0;
    end else if (load_en) begin
      instr_d = load_data;
      pc_d    = load_pc;
      pc4_d   = load_pc + ADDR_W'(4);
      valid_d = 1'b1;
      mis_d   = 1'b0;
    end else if (mis_load) begin
      instr_d = NOP_INSTR;
      pc_d    = PC_IF;
      pc4_d   = PC_IF + ADDR_W'(4);
      valid_d = 1'b1;
      mis_d   = 1'b1;
    end else if (valid_q && !id_stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      mis_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign Instr_ID    = instr_q;
  assign PC_ID       = pc_q;
  assign PC_Plus4_ID = pc4_q;
  assign Valid_ID    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed-vector bench for if_fetch_stage; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC_IF;
  logic        pc_stall, imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall, if_flush;
  logic [31:0] Instr_ID, PC_ID, PC_Plus4_ID;
  logic        Valid_ID;
`ifdef IF_MISALIGN_CHK_EN
  logic        Misalign_ID;
`endif

  int n_vec = 0;
  int n_err = 0;

  if_fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .PC_IF(PC_IF), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .if_flush(if_flush),
    .Instr_ID(Instr_ID), .PC_ID(PC_ID), .PC_Plus4_ID(PC_Plus4_ID),
`ifdef IF_MISALIGN_CHK_EN
    .Misalign_ID(Misalign_ID),
`endif
    .Valid_ID(Valid_ID)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; PC_IF = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    id_stall = 0; if_flush = 0;
    @(negedge Clk); @(negedge Clk);
    chk("rst_valid", 64'(Valid_ID), 64'd0);
    chk("rst_instr", 64'(Instr_ID), 64'h0);
    chk("rst_pc", 64'(PC_ID), 64'h0);
    chk("rst_pc4", 64'(PC_Plus4_ID), 64'h0);
    chk("rst_req", 64'(imem_req), 64'd0);

    // Single fetch
    Reset = 1'b0; PC_IF = 32'h0040_0000; imem_gnt = 1;
    #1;
    chk("t1_req", 64'(imem_req), 64'd1);
    chk("t1_addr", 64'(imem_addr), 64'h0040_0000);
    chk("t1_stall_gnt", 64'(pc_stall), 64'd0);
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2008_0005;
    #1;
    chk("t1_stall_wait", 64'(pc_stall), 64'd1);
    chk("t1_req_wait", 64'(imem_req), 64'd0);
    tick();
    imem_rvalid = 0;
    chk("t1_valid", 64'(Valid_ID), 64'd1);
    chk("t1_instr", 64'(Instr_ID), 64'h2008_0005);
    chk("t1_pc", 64'(PC_ID), 64'h0040_0000);
    chk("t1_pc4", 64'(PC_Plus4_ID), 64'h0040_0004);

    // Sustained fetch: one instruction every second cycle
    imem_gnt = 1; imem_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      PC_IF = 32'(4 * i); imem_rdata = 32'h1000 + 32'(i);
      #1;
      chk($sformatf("t2_stall_req%0d", i), 64'(pc_stall), 64'd0);
      tick();
      chk($sformatf("t2_bubble%0d", i), 64'(Valid_ID), 64'd0);
      chk($sformatf("t2_stall_wait%0d", i), 64'(pc_stall), 64'd1);
      tick();
      chk($sformatf("t2_valid%0d", i), 64'(Valid_ID), 64'd1);
      chk($sformatf("t2_pc%0d", i), 64'(PC_ID), 64'(4 * i));
      chk($sformatf("t2_instr%0d", i), 64'(Instr_ID), 64'h1000 + 64'(i));
    end

    // Decode stall while a response arrives -> FULL, then drain
    id_stall = 1; PC_IF = 32'h0000_000C; imem_rvalid = 0;
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 0;
    #1;
    chk("t3_full_instr", 64'(Instr_ID), 64'h1002);
    chk("t3_full_pc", 64'(PC_ID), 64'h8);
    chk("t3_full_req", 64'(imem_req), 64'd0);
    chk("t3_full_stall", 64'(pc_stall), 64'd1);
    tick();
    chk("t3_hold_instr", 64'(Instr_ID), 64'h1002);
    id_stall = 0;
    tick();
    chk("t3_drain_instr", 64'(Instr_ID), 64'h1234_5678);
    chk("t3_drain_pc", 64'(PC_ID), 64'hC);
    chk("t3_drain_pc4", 64'(PC_Plus4_ID), 64'h10);
    chk("t3_drain_valid", 64'(Valid_ID), 64'd1);

    // Flush overrides decode stall
    id_stall = 1; if_flush = 1;
    tick();
    chk("t4_flush_valid", 64'(Valid_ID), 64'd0);
    chk("t4_flush_instr", 64'(Instr_ID), 64'h0);
    chk("t4_flush_req", 64'(imem_req), 64'd1);

    // Flush in WAIT drops the late response
    id_stall = 0; if_flush = 0; PC_IF = 32'h0000_0100; imem_gnt = 1;
    tick();
    imem_gnt = 0; if_flush = 1;
    #1;
    chk("t4_stall_flush", 64'(pc_stall), 64'd0);
    tick();
    if_flush = 0;
    tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 0;
    chk("t4_drop_valid", 64'(Valid_ID), 64'd0);
    chk("t4_drop_instr", 64'(Instr_ID), 64'h0);
    chk("t4_back_req", 64'(imem_req), 64'd1);
    tick();
    chk("t4_drop_instr2", 64'(Instr_ID), 64'h0);

    // Async reset in WAIT, late response afterwards ignored
    PC_IF = 32'h0000_0200; imem_gnt = 1;
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hAAAA_0001;
    tick();
    imem_rvalid = 0; id_stall = 1; PC_IF = 32'h0000_0204; imem_gnt = 1;
    chk("t5_pre_valid", 64'(Valid_ID), 64'd1);
    tick();
    imem_gnt = 0;
    #2 Reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(Valid_ID), 64'd0);
    chk("t5_rst_req", 64'(imem_req), 64'd0);
    chk("t5_rst_instr", 64'(Instr_ID), 64'h0);
    chk("t5_rst_pc", 64'(PC_ID), 64'h0);
    @(negedge Clk);
    Reset = 1'b0; id_stall = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0BAD;
    tick();
    imem_rvalid = 0;
    chk("t5_late_valid", 64'(Valid_ID), 64'd0);
    chk("t5_late_instr", 64'(Instr_ID), 64'h0);
    chk("t5_still_req", 64'(imem_req), 64'd1);

    // PC+4 wraps at the top of the address space
    PC_IF = 32'hFFFF_FFFC; imem_gnt = 1;
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0003;
    tick();
    imem_rvalid = 0;
    chk("t6_pc", 64'(PC_ID), 64'hFFFF_FFFC);
    chk("t6_pc4", 64'(PC_Plus4_ID), 64'h0);
    chk("t6_instr", 64'(Instr_ID), 64'h3);

`ifdef IF_MISALIGN_CHK_EN
    PC_IF = 32'h0040_0002; imem_gnt = 1;
    #1;
    chk("t7_req", 64'(imem_req), 64'd0);
    chk("t7_stall", 64'(pc_stall), 64'd0);
    tick();
    chk("t7_mis", 64'(Misalign_ID), 64'd1);
    chk("t7_valid", 64'(Valid_ID), 64'd1);
    chk("t7_instr", 64'(Instr_ID), 64'h0);
    chk("t7_pc", 64'(PC_ID), 64'h0040_0002);
    PC_IF = 32'h0040_0004; imem_gnt = 0;
    tick();
    chk("t7_mis_clr", 64'(Misalign_ID), 64'd0);
    chk("t7_consumed", 64'(Valid_ID), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
